ula_vtiming_prog: RTL and testbench
===================================

Name: ula_vtiming_prog

Overview:
- Runtime-programmable raster timing generator for the Spectrum video path. Generalises the fixed ZX48/ZX128/Pentagon counters.
- Produces pixel/line counters, the border flag, sync/blank pulses, the frame interrupt and the flash counter.
- Adds an optional raster line interrupt.
- Timing registers are written by the CPU-side port decoder into shadow copies. Shadow copies become active only at frame wrap, so a mode change never tears a frame.

Parameters:
- HCW, 9: width of horizontal counter and H timing registers.
- VCW, 9: width of vertical counter and V timing registers.
- HACT, 256: active pixels per line; hc >= HACT is border.
- VACT, 192: active lines; vc >= VACT is border.
- INTW, 7: width of interrupt-length register/counter.

Ports:
- clk_sys  in  1  master clock; one clock, all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ce_pix  in  1  pixel clock enable (7 MHz, ce_7mn phase); counters and outputs update only when high.
- cfg_we  in  1  register write strobe, one clk_sys cycle per write.
- cfg_addr  in  4  register index.
- cfg_din  in  16  write data; low HCW/VCW/INTW bits used.
- cfg_dout  out  16  shadow register at cfg_addr; combinational, zero-extended; unmapped indices read 0.
- hc  out  HCW  horizontal counter.
- vc  out  VCW  vertical counter.
- border  out  1  registered border flag.
- HSync, VSync, HBlank, VBlank  out  1 each  registered sync/blank.
- nINT  out  1  frame interrupt, active low.
- line_int  out  1  raster line interrupt pulse, active high.
- frame_start  out  1  one-ce_pix-cycle pulse when hc=0, vc=0 is entered.
- flash_cnt  out  5  frame counter; bit 4 is the flash phase.

Behaviour:
- Register map (shadow, reset value = ZX48):
  - 0 HTOTAL = 447, 1 VTOTAL = 311
  - 2 HBLS = 312, 3 HBLE = 416
  - 4 HSS = 336, 5 HSE = 368
  - 6 VBLS = 232, 7 VBLE = 257
  - 8 VSS = 240, 9 VSE = 244
  - A INTLINE = 248, B INTHPOS = 4, C INTLEN = 63
  - D LINTLINE = 0, E LINTCTL = 0 (bit0 enable)
- Write: on cfg_we, shadow[cfg_addr] <= cfg_din (truncated). Writes to F are ignored.
- Counters, advanced on ce_pix only:
  - hc_next = (hc == HTOTAL_act) ? 0 : hc+1.
  - On hc wrap: vc_next = (vc == VTOTAL_act) ? 0 : vc+1.
  - On vc wrap: flash_cnt increments mod 32.
- Apply: in the ce_pix cycle where hc_next=0 and vc_next=0, all active registers <= shadow. Shadow values are those before any same-cycle cfg_we, so a colliding write takes effect next frame. frame_start pulses in the same ce_pix cycle.
- All outputs below are registered and decoded from hc_next/vc_next against active registers (zero latency relative to the counters):
  - border <= (hc_next >= HACT) | (vc_next >= VACT).
  - HBlank <= 1 when hc_next == HBLS, <= 0 when hc_next == HBLE. The same scheme applies to HSync (HSS/HSE), VBlank and VSync (VBLS/VBLE, VSS/VSE).
  - If start == end, set wins.
  - A start/end beyond the total never matches; the output holds its state.
- Frame interrupt:
  - When vc_next == INTLINE and hc_next == INTHPOS: INT <= 1, counter loaded with INTLEN.
  - While INT: counter decrements each ce_pix; INT clears when the counter reaches 0. Asserted length = INTLEN+1 ce_pix cycles.
  - A retrigger while INT is active is ignored.
  - INTLEN = 0 gives a 1-cycle pulse.
  - nINT = ~INT.
- Reset values:
  - hc = 0, vc = 0, flash_cnt = 0.
  - All outputs inactive: nINT = 1, line_int = 0, frame_start = 0, sync/blank = 0, border = 0.
  - Shadow and active registers = table values.
  - Reset mid-frame aborts an in-progress interrupt and discards unapplied shadow writes.
- No clamping. A total below HACT/VACT yields a permanently active (non-border) region on that axis.

Optional Feature:
- Macro: ULA_VTIMING_LINE_INT_EN.
- Defined: line_int pulses for one ce_pix cycle when LINTCTL[0] = 1, vc_next == LINTLINE and hc_next == 0. Registers D/E are read/writable and applied at frame wrap like the others.
- Undefined: line_int tied 0. Registers D/E are not implemented: writes are ignored and reads return 0.

Test Plan:
- Reset, free-run ce_pix every cycle -> hc wraps 447->0; vc wraps 311->0 after 448*312 ce_pix; frame_start every 139776 ce_pix; flash_cnt bit4 toggles every 16 frames.
- Default timing -> HBlank high hc 312..415, HSync high hc 336..367; VSync high lines 240..243; nINT low 64 ce_pix starting at vc=248, hc=4.
- Mid-frame write HTOTAL=455, VTOTAL=310 -> current frame keeps 448x312; next frame is 456x311, and cfg_dout at index 0 reads 455 immediately.
- cfg_we on the wrap ce_pix cycle writing INTLEN=3 -> following frame still uses 63; frame after that asserts nINT for 4 ce_pix.
- INTLEN=0, HSS=HSE=340 -> nINT 1-cycle pulse; HSync set at 340 and stays high (set wins) until reset.
- With ULA_VTIMING_LINE_INT_EN: LINTLINE=100, LINTCTL=1, applied -> line_int pulse at vc=100, hc=0 every frame. Without the macro: writes to D read back 0 and line_int stays 0.

Source files
------------

// File: rtl/ula_vtiming_prog.sv
// ula_vtiming_prog: runtime-programmable Spectrum raster timing generator.
// Shadow timing registers are written by the CPU port decoder and copied
// into the active set only at frame wrap, so a mode change never tears.
// Ports: clk_sys/reset (sync, active high), ce_pix pixel enable,
//   cfg_we/cfg_addr/cfg_din/cfg_dout shadow register access,
//   hc/vc counters, border, HSync/VSync/HBlank/VBlank, nINT, line_int,
//   frame_start, flash_cnt.
// Optional macro ULA_VTIMING_LINE_INT_EN adds the raster line interrupt
// (registers D/E); without it line_int is 0 and D/E read as 0.
module ula_vtiming_prog #(
    parameter int HCW  = 9,
    parameter int VCW  = 9,
    parameter int HACT = 256,
    parameter int VACT = 192,
    parameter int INTW = 7
) (
    input  logic           clk_sys,
    input  logic           reset,
    input  logic           ce_pix,
    input  logic           cfg_we,
    input  logic [3:0]     cfg_addr,
    input  logic [15:0]    cfg_din,
    output logic [15:0]    cfg_dout,
    output logic [HCW-1:0] hc,
    output logic [VCW-1:0] vc,
    output logic           border,
    output logic           HSync,
    output logic           VSync,
    output logic           HBlank,
    output logic           VBlank,
    output logic           nINT,
    output logic           line_int,
    output logic           frame_start,
    output logic [4:0]     flash_cnt
);

    typedef struct packed {
        logic [HCW-1:0]  htotal;
        logic [VCW-1:0]  vtotal;
        logic [HCW-1:0]  hbls;
        logic [HCW-1:0]  hble;
        logic [HCW-1:0]  hss;
        logic [HCW-1:0]  hse;
        logic [VCW-1:0]  vbls;
        logic [VCW-1:0]  vble;
        logic [VCW-1:0]  vss;
        logic [VCW-1:0]  vse;
        logic [VCW-1:0]  intline;
        logic [HCW-1:0]  inthpos;
        logic [INTW-1:0] intlen;
`ifdef ULA_VTIMING_LINE_INT_EN
        logic [VCW-1:0]  lintline;
        logic            lintctl;
`endif
    } regs_t;

    // ZX48 timing
    function automatic regs_t regs_rst();
        regs_t r;
        r         = '0;
        r.htotal  = HCW'(447);
        r.vtotal  = VCW'(311);
        r.hbls    = HCW'(312);
        r.hble    = HCW'(416);
        r.hss     = HCW'(336);
        r.hse     = HCW'(368);
        r.vbls    = VCW'(232);
        r.vble    = VCW'(257);
        r.vss     = VCW'(240);
        r.vse     = VCW'(244);
        r.intline = VCW'(248);
        r.inthpos = HCW'(4);
        r.intlen  = INTW'(63);
        return r;
    endfunction

    localparam regs_t          REGS_RST = regs_rst();
    localparam logic [HCW-1:0] HACT_W   = HCW'(HACT);
    localparam logic [VCW-1:0] VACT_W   = VCW'(VACT);

    // Set/clear with hold; set wins when start == end.
    function automatic logic hset(input logic cur,
                                  input logic [HCW-1:0] p,
                                  input logic [HCW-1:0] s,
                                  input logic [HCW-1:0] e);
        if (p == s) return 1'b1;
        if (p == e) return 1'b0;
        return cur;
    endfunction

    function automatic logic vset(input logic cur,
                                  input logic [VCW-1:0] p,
                                  input logic [VCW-1:0] s,
                                  input logic [VCW-1:0] e);
        if (p == s) return 1'b1;
        if (p == e) return 1'b0;
        return cur;
    endfunction

    regs_t           shadow_q, shadow_d;
    regs_t           active_q, active_d;
    regs_t           eff;
    logic [HCW-1:0]  hc_q, hc_d, hc_nx;
    logic [VCW-1:0]  vc_q, vc_d, vc_nx;
    logic            hwrap, vwrap, fwrap;
    logic [4:0]      flash_q, flash_d;
    logic            border_q, border_d;
    logic            hsync_q, hsync_d;
    logic            hblank_q, hblank_d;
    logic            vsync_q, vsync_d;
    logic            vblank_q, vblank_d;
    logic            int_q, int_d;
    logic [INTW-1:0] int_cnt_q, int_cnt_d;
    logic            fstart_q, fstart_d;
    logic            cfg_din_unused;

    assign cfg_din_unused = ^cfg_din;

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        hc_d      = hc_q;
        vc_d      = vc_q;
        flash_d   = flash_q;
        border_d  = border_q;
        hsync_d   = hsync_q;
        hblank_d  = hblank_q;
        vsync_d   = vsync_q;
        vblank_d  = vblank_q;
        int_d     = int_q;
        int_cnt_d = int_cnt_q;
        fstart_d  = fstart_q;

        hwrap = (hc_q == active_q.htotal);
        vwrap = (vc_q == active_q.vtotal);
        fwrap = hwrap && vwrap;
        hc_nx = hwrap ? '0 : hc_q + HCW'(1);
        if (!hwrap)
            vc_nx = vc_q;
        else
            vc_nx = vwrap ? '0 : vc_q + VCW'(1);

        // Decode at the new position with the registers that will be
        // in force there, i.e. the shadow set on the wrap cycle.
        eff = fwrap ? shadow_q : active_q;

        if (ce_pix) begin
            hc_d     = hc_nx;
            vc_d     = vc_nx;
            fstart_d = fwrap;
            if (fwrap) begin
                active_d = shadow_q;
                flash_d  = flash_q + 5'd1;
            end
            border_d = (hc_nx >= HACT_W) | (vc_nx >= VACT_W);
            hblank_d = hset(hblank_q, hc_nx, eff.hbls, eff.hble);
            hsync_d  = hset(hsync_q, hc_nx, eff.hss, eff.hse);
            vblank_d = vset(vblank_q, vc_nx, eff.vbls, eff.vble);
            vsync_d  = vset(vsync_q, vc_nx, eff.vss, eff.vse);
            if (int_q) begin
                if (int_cnt_q == '0)
                    int_d = 1'b0;
                else
                    int_cnt_d = int_cnt_q - INTW'(1);
            end else if (vc_nx == eff.intline &&
                         hc_nx == eff.inthpos) begin
                int_d     = 1'b1;
                int_cnt_d = eff.intlen;
            end
        end

        if (cfg_we) begin
            case (cfg_addr)
                4'h0: shadow_d.htotal  = cfg_din[HCW-1:0];
                4'h1: shadow_d.vtotal  = cfg_din[VCW-1:0];
                4'h2: shadow_d.hbls    = cfg_din[HCW-1:0];
                4'h3: shadow_d.hble    = cfg_din[HCW-1:0];
                4'h4: shadow_d.hss     = cfg_din[HCW-1:0];
                4'h5: shadow_d.hse     = cfg_din[HCW-1:0];
                4'h6: shadow_d.vbls    = cfg_din[VCW-1:0];
                4'h7: shadow_d.vble    = cfg_din[VCW-1:0];
                4'h8: shadow_d.vss     = cfg_din[VCW-1:0];
                4'h9: shadow_d.vse     = cfg_din[VCW-1:0];
                4'hA: shadow_d.intline = cfg_din[VCW-1:0];
                4'hB: shadow_d.inthpos = cfg_din[HCW-1:0];
                4'hC: shadow_d.intlen  = cfg_din[INTW-1:0];
`ifdef ULA_VTIMING_LINE_INT_EN
                4'hD: shadow_d.lintline = cfg_din[VCW-1:0];
                4'hE: shadow_d.lintctl  = cfg_din[0];
`endif
                default: ;
            endcase
        end
    end

`ifdef ULA_VTIMING_LINE_INT_EN
    logic line_int_q, line_int_d;

    always_comb begin
        line_int_d = line_int_q;
        if (ce_pix)
            line_int_d = eff.lintctl && (vc_nx == eff.lintline) &&
                         (hc_nx == '0);
    end

    always_ff @(posedge clk_sys) begin
        if (reset)
            line_int_q <= 1'b0;
        else
            line_int_q <= line_int_d;
    end

    assign line_int = line_int_q;
`else
    assign line_int = 1'b0;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            shadow_q  <= REGS_RST;
            active_q  <= REGS_RST;
            hc_q      <= '0;
            vc_q      <= '0;
            flash_q   <= '0;
            border_q  <= 1'b0;
            hsync_q   <= 1'b0;
            hblank_q  <= 1'b0;
            vsync_q   <= 1'b0;
            vblank_q  <= 1'b0;
            int_q     <= 1'b0;
            int_cnt_q <= '0;
            fstart_q  <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            flash_q   <= flash_d;
            border_q  <= border_d;
            hsync_q   <= hsync_d;
            hblank_q  <= hblank_d;
            vsync_q   <= vsync_d;
            vblank_q  <= vblank_d;
            int_q     <= int_d;
            int_cnt_q <= int_cnt_d;
            fstart_q  <= fstart_d;
        end
    end

    always_comb begin
        cfg_dout = '0;
        case (cfg_addr)
            4'h0: cfg_dout = 16'(shadow_q.htotal);
            4'h1: cfg_dout = 16'(shadow_q.vtotal);
            4'h2: cfg_dout = 16'(shadow_q.hbls);
            4'h3: cfg_dout = 16'(shadow_q.hble);
            4'h4: cfg_dout = 16'(shadow_q.hss);
            4'h5: cfg_dout = 16'(shadow_q.hse);
            4'h6: cfg_dout = 16'(shadow_q.vbls);
            4'h7: cfg_dout = 16'(shadow_q.vble);
            4'h8: cfg_dout = 16'(shadow_q.vss);
            4'h9: cfg_dout = 16'(shadow_q.vse);
            4'hA: cfg_dout = 16'(shadow_q.intline);
            4'hB: cfg_dout = 16'(shadow_q.inthpos);
            4'hC: cfg_dout = 16'(shadow_q.intlen);
`ifdef ULA_VTIMING_LINE_INT_EN
            4'hD: cfg_dout = 16'(shadow_q.lintline);
            4'hE: cfg_dout = 16'(shadow_q.lintctl);
`endif
            default: cfg_dout = '0;
        endcase
    end

    assign hc          = hc_q;
    assign vc          = vc_q;
    assign border      = border_q;
    assign HSync       = hsync_q;
    assign HBlank      = hblank_q;
    assign VSync       = vsync_q;
    assign VBlank      = vblank_q;
    assign nINT        = ~int_q;
    assign frame_start = fstart_q;
    assign flash_cnt   = flash_q;

endmodule

// File: tb/tb_ula_vtiming_prog.sv
// tb_ula_vtiming_prog: randomized bench for ula_vtiming_prog, checked
// every cycle against a frame-level reference model of the timing rules.
module tb_ula_vtiming_prog;

    // Narrow vertical width keeps the fixed reset frame short (448x56).
    localparam int HCW  = 9;
    localparam int VCW  = 6;
    localparam int HACT = 20;
    localparam int VACT = 10;
    localparam int INTW = 7;
`ifdef ULA_VTIMING_LINE_INT_EN
    localparam bit LIE = 1'b1;
`else
    localparam bit LIE = 1'b0;
`endif

    logic           clk_sys = 1'b0;
    logic           reset, ce_pix, cfg_we;
    logic [3:0]     cfg_addr;
    logic [15:0]    cfg_din, cfg_dout;
    logic [HCW-1:0] hc;
    logic [VCW-1:0] vc;
    logic           border, HSync, VSync, HBlank, VBlank;
    logic           nINT, line_int, frame_start;
    logic [4:0]     flash_cnt;

    ula_vtiming_prog #(
        .HCW(HCW), .VCW(VCW), .HACT(HACT), .VACT(VACT), .INTW(INTW)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_din(cfg_din),
        .cfg_dout(cfg_dout), .hc(hc), .vc(vc), .border(border),
        .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
        .nINT(nINT), .line_int(line_int), .frame_start(frame_start),
        .flash_cnt(flash_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int rv[16] = '{447, 311, 312, 416, 336, 368, 232, 257,
                   240, 244, 248, 4, 63, 0, 0, 0};
    int sh[16];
    int ac[16];
    int mhc, mvc, mfl, mleft;
    bit mhb, mhs, mvb, mvs, mbd, mfs, mli;

    function automatic int wmask(input int i);
        case (i)
            0, 2, 3, 4, 5, 11:     return (1 << HCW) - 1;
            1, 6, 7, 8, 9, 10:     return (1 << VCW) - 1;
            12:                    return (1 << INTW) - 1;
            13:                    return LIE ? (1 << VCW) - 1 : 0;
            14:                    return LIE ? 1 : 0;
            default:               return 0;
        endcase
    endfunction

    function automatic bit sr(input bit cur, input int p, input int s,
                              input int e);
        if (p == s) return 1'b1;
        if (p == e) return 1'b0;
        return cur;
    endfunction

    task automatic mreset();
        for (int i = 0; i < 16; i++) begin
            sh[i] = rv[i] & wmask(i);
            ac[i] = sh[i];
        end
        mhc = 0; mvc = 0; mfl = 0; mleft = 0;
        mhb = 0; mhs = 0; mvb = 0; mvs = 0;
        mbd = 0; mfs = 0; mli = 0;
    endtask

    // One clk_sys edge with the inputs currently driven.
    task automatic mstep();
        int hn, vn;
        bit eol, eof;
        if (reset) begin
            mreset();
            return;
        end
        if (ce_pix) begin
            eol = (mhc == ac[0]);
            eof = eol && (mvc == ac[1]);
            hn  = eol ? 0 : mhc + 1;
            vn  = !eol ? mvc : (eof ? 0 : mvc + 1);
            if (eof) begin
                ac  = sh;
                mfl = (mfl + 1) % 32;
            end
            mfs = eof;
            mhc = hn;
            mvc = vn;
            mbd = (hn >= HACT) || (vn >= VACT);
            mhb = sr(mhb, hn, ac[2], ac[3]);
            mhs = sr(mhs, hn, ac[4], ac[5]);
            mvb = sr(mvb, vn, ac[6], ac[7]);
            mvs = sr(mvs, vn, ac[8], ac[9]);
            if (mleft > 0)
                mleft--;
            else if (vn == ac[10] && hn == ac[11])
                mleft = ac[12] + 1;
            mli = LIE && (ac[14] & 1) && vn == ac[13] && hn == 0;
        end
        if (cfg_we)
            sh[cfg_addr] = int'(cfg_din) & wmask(int'(cfg_addr));
    endtask

    task automatic check_all();
        chk("hc", 32'(hc), mhc);
        chk("vc", 32'(vc), mvc);
        chk("flash_cnt", 32'(flash_cnt), mfl);
        chk("frame_start", 32'(frame_start), 32'(mfs));
        chk("border", 32'(border), 32'(mbd));
        chk("HBlank", 32'(HBlank), 32'(mhb));
        chk("HSync", 32'(HSync), 32'(mhs));
        chk("VBlank", 32'(VBlank), 32'(mvb));
        chk("VSync", 32'(VSync), 32'(mvs));
        chk("nINT", 32'(nINT), (mleft > 0) ? 0 : 1);
        chk("line_int", 32'(line_int), 32'(mli));
        chk("cfg_dout", 32'(cfg_dout), sh[cfg_addr]);
    endtask

    task automatic cyc(input logic r, input logic ce, input logic we,
                       input logic [3:0] a, input logic [15:0] d);
        reset    = r;
        ce_pix   = ce;
        cfg_we   = we;
        cfg_addr = a;
        cfg_din  = d;
        @(posedge clk_sys);
        mstep();
        #1;
        check_all();
    endtask

    // Small frame timings so many frames fit the run; upper data bits
    // carry junk that the register widths must discard.
    function automatic logic [15:0] gen(input int a);
        int v;
        case (a)
            0:                  v = $urandom_range(6, 40);
            1:                  v = $urandom_range(3, 20);
            2, 3, 4, 5, 11:     v = $urandom_range(0, 44);
            6, 7, 8, 9, 10, 13: v = $urandom_range(0, 22);
            12:                 v = $urandom_range(0, 40);
            14:                 v = $urandom_range(0, 1);
            default:            v = $urandom_range(0, 65535);
        endcase
        if ((a == 3 || a == 5 || a == 7 || a == 9) &&
            $urandom_range(0, 3) == 0)
            v = sh[a-1];
        return 16'(v) | (16'($urandom) & 16'hFC00);
    endfunction

    task automatic pick(input int rate, output logic we,
                        output logic [3:0] a, output logic [15:0] d);
        we = ($urandom_range(0, rate - 1) == 0);
        a  = 4'($urandom_range(0, 15));
        d  = gen(int'(a));
    endtask

    initial begin
        logic we, ce;
        logic [3:0] a;
        logic [15:0] d;

        mreset();
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b1, 1'b0, 4'(i), 16'h0);

        // reset values visible through every register index
        for (int i = 0; i < 16; i++)
            cyc(1'b1, 1'b0, 1'b0, 4'(i), 16'h0);

        // program a small next frame, then run the default frame out
        cyc(1'b0, 1'b1, 1'b1, 4'h0, gen(0));
        cyc(1'b0, 1'b1, 1'b1, 4'h1, gen(1));
        cyc(1'b0, 1'b1, 1'b1, 4'hE, 16'h0001);
        for (int i = 0; i < 448 * 56 + 200 && n_bad < 40; i++) begin
            pick(256, we, a, d);
            cyc(1'b0, 1'b1, we, a, d);
        end

        // random ce_pix and writes, including writes on the wrap cycle
        for (int i = 0; i < 30000 && n_bad < 40; i++) begin
            ce = ($urandom_range(0, 3) != 0);
            pick(64, we, a, d);
            if (ce && mhc == ac[0] && mvc == ac[1] &&
                $urandom_range(0, 1) == 1) begin
                we = 1'b1;
                a  = ($urandom_range(0, 1) == 1) ? 4'hC :
                     4'($urandom_range(0, 15));
                d  = gen(int'(a));
            end
            cyc(1'b0, ce, we, a, d);
        end

        // unapplied writes, then reset mid-frame
        for (int i = 0; i < 16; i++)
            cyc(1'b0, 1'b1, 1'b1, 4'(i), gen(i));
        cyc(1'b1, 1'b1, 1'b1, 4'h0, gen(0));
        for (int i = 0; i < 600 && n_bad < 40; i++)
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 4'(i % 16), 16'h0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
